memory_param: RTL and testbench
===============================

MEMORY_PARAM -- requirements
Module: memory_param

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: the word address width; depth is 2**ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 32: the word width, a multiple of 8 and at least 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port WrEn, input, 1 bit: write request.
REQ-006 The block SHALL have port RdEn, input, 1 bit: read request.
REQ-007 The block SHALL have port Opcode, input, 2 bits: access size for both reads and writes; 0=word, 1=halfword, 2=byte, 3=bit.
REQ-008 The block SHALL have port Addr, input, ADDR_W bits: word address.
REQ-009 The block SHALL have port ByteAddr, input, log2(DATA_W/8) bits: byte lane within the word.
REQ-010 The block SHALL have port BitAddr, input, log2(DATA_W) bits: bit within the word.
REQ-011 The block SHALL have port WrBus, input, DATA_W bits: write data, right-justified.
REQ-012 The block SHALL have port RdBus, output, DATA_W bits: read data, right-justified and zero-extended.
REQ-013 The block SHALL have port RdValid, output, 1 bit: a one-cycle pulse marking valid RdBus.
REQ-014 The block SHALL have port Ready, output, 1 bit: the block accepts requests.

Function
REQ-015 The block SHALL implement the states INIT and IDLE.
- INIT: clears one word per cycle, address 0 up to 2**ADDR_W-1; Ready=0; moves to IDLE after the last word.
REQ-016 A request SHALL be accepted only in a cycle with Ready=1 and WrEn or RdEn high; requests made while Ready=0 SHALL be ignored with no side effects.
REQ-017 Writes SHALL update only the addressed field; all other bits of the word are preserved.
- word: all bits.
- halfword: the lanes selected by ByteAddr with its LSB ignored.
- byte: lane ByteAddr.
- bit: WrBus[0] into bit BitAddr.
REQ-018 Reads SHALL have one-cycle latency: RdBus and the RdValid pulse appear on the cycle after acceptance.
- The field is extracted per Opcode as in REQ-017 and zero-extended.
REQ-019 RdBus SHALL hold its last value while RdValid=0.
REQ-020 Back-to-back reads SHALL be supported, one per cycle, with a RdValid pulse for each.
REQ-021 When WrEn and RdEn are accepted in the same cycle, both SHALL execute, and the read SHALL return the pre-write data (read-before-write).
REQ-022 A write followed by a read of the same address on the next cycle SHALL return the new data.

Reset
REQ-023 Asserting reset SHALL immediately force RdBus=0, RdValid=0, Ready=0 and state INIT, with the clear pointer at 0.
REQ-024 A reset asserted mid-read or mid-INIT SHALL drop the in-flight read (no RdValid) and restart the full clear sweep after reset deasserts.

Configuration
REQ-025 With macro MEMORY_PARAM_PARITY_EN defined, the block SHALL:
- store one even-parity bit per byte lane, updated on every write that touches that byte (including bit writes);
- add input ParInj (1 bit): when high on an accepted write, the stored parity of the written lanes is inverted;
- add output RdErr (1 bit), valid with RdValid: set if any byte of the addressed word fails parity, regardless of Opcode;
- clear parity to 0 during INIT.
REQ-026 Without the macro, ParInj, RdErr and the parity storage SHALL be absent.

Structure
REQ-027 A shared package mem_pkg SHALL hold the Opcode enumeration (OP_WORD, OP_HALF, OP_BYTE, OP_BIT) and the state enumeration (ST_INIT, ST_IDLE).
REQ-028 A sub-module mem_field SHALL hold the combinational write-mask generation and read-field extraction, parametrised by DATA_W.

Verification
REQ-029 The bench SHALL cover the following directed scenarios, each at ADDR_W=4 and DATA_W=32:
- Reset: release reset -> Ready=0 for exactly 16 cycles, then Ready=1; a read of any address returns 0.
- Field writes:
  - word write 0xDEADBEEF to address 3, then byte write 0x11 at ByteAddr=2 -> word read of address 3 returns 0xDE11BEEF;
  - bit write 0 at BitAddr=31 -> word read returns 0x5E11BEEF.
- Field reads:
  - address 3 holding 0x5E11BEEF: halfword read with ByteAddr=2 -> 0x00005E11;
  - bit read at BitAddr=0 -> 0x00000001.
- Simultaneous access: WrEn and RdEn on address 5 (holding 0) with word write 0xA5A5A5A5 -> RdBus=0 with RdValid the next cycle; the following read returns 0xA5A5A5A5.
- Back-to-back and reset: 4 consecutive reads of addresses 0..3 -> 4 consecutive RdValid pulses with matching data; reset asserted in the cycle after a read is accepted -> no RdValid, and the INIT sweep restarts.
- Parity (MEMORY_PARAM_PARITY_EN defined): write to address 7 with ParInj=1, then read address 7 -> RdErr=1 with RdValid; rewrite with ParInj=0, then read -> RdErr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared types for memory_param and its field helper.
//   opcode_e : access size used for both reads and writes
//   state_e  : controller state (clear sweep / serving requests)
// ----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        OP_WORD = 2'd0,
        OP_HALF = 2'd1,
        OP_BYTE = 2'd2,
        OP_BIT  = 2'd3
    } opcode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/mem_field.sv
// ----------------------------------------------------------------------------
// mem_field
// Combinational field helper: builds the bit mask of the addressed field,
// aligns right-justified write data onto that field, and extracts the same
// field from a stored word (right-justified, zero-extended).
// Ports:
//   opcode     in  : access size (mem_pkg::opcode_e encoding)
//   byte_addr  in  : byte lane within the word
//   bit_addr   in  : bit within the word
//   wr_data    in  : right-justified write data
//   word       in  : stored word to extract from
//   field_mask out : ones over the addressed field
//   wr_aligned out : write data shifted into the field, masked
//   rd_field   out : addressed field of 'word', right-justified
// ----------------------------------------------------------------------------
module mem_field
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    opcode,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_addr,
    input  logic [$clog2(DATA_W)-1:0]     bit_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [DATA_W-1:0]             word,
    output logic [DATA_W-1:0]             field_mask,
    output logic [DATA_W-1:0]             wr_aligned,
    output logic [DATA_W-1:0]             rd_field
);

    localparam int BA_W  = $clog2(DATA_W/8);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] HALF_ONES = DATA_W'(17'h0FFFF);
    localparam logic [DATA_W-1:0] BYTE_ONES = DATA_W'(9'h0FF);
    localparam logic [DATA_W-1:0] BIT_ONE   = DATA_W'(1);

    opcode_e          op;
    logic [BIT_W-1:0] shift;
    logic [BA_W-1:0]  half_lane;

    assign op = opcode_e'(opcode);

    // Halfwords sit on even lanes: the lane LSB is dropped.
    assign half_lane = byte_addr & ~BA_W'(1);

    always_comb begin
        field_mask = '1;
        shift      = '0;
        case (op)
            OP_WORD: begin
                field_mask = '1;
                shift      = '0;
            end
            OP_HALF: begin
                shift      = {half_lane, 3'b000};
                field_mask = HALF_ONES << shift;
            end
            OP_BYTE: begin
                shift      = {byte_addr, 3'b000};
                field_mask = BYTE_ONES << shift;
            end
            OP_BIT: begin
                shift      = bit_addr;
                field_mask = BIT_ONE << shift;
            end
            default: begin
                field_mask = '1;
                shift      = '0;
            end
        endcase
    end

    // Upper bits of wr_data beyond the field width fall outside the mask.
    assign wr_aligned = (wr_data << shift) & field_mask;
    assign rd_field   = (word & field_mask) >> shift;

endmodule

// File: rtl/memory_param.sv
// ----------------------------------------------------------------------------
// memory_param
// Word-addressed memory with word/halfword/byte/bit access sizes.
// After reset the block sweeps every word to zero (one per cycle, Ready=0),
// then serves requests. Reads have one-cycle latency with a RdValid pulse;
// a simultaneous read and write both execute and the read sees old data.
// Optional feature macro: MEMORY_PARAM_PARITY_EN adds per-lane even parity,
// the ParInj error-injection input and the RdErr output.
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : asynchronous active-low reset
//   WrEn     in  : write request
//   RdEn     in  : read request
//   Opcode   in  : 0=word 1=halfword 2=byte 3=bit
//   Addr     in  : word address
//   ByteAddr in  : byte lane within the word
//   BitAddr  in  : bit within the word
//   WrBus    in  : right-justified write data
//   ParInj   in  : (parity build) invert stored parity of written lanes
//   RdErr    out : (parity build) parity error on the read word, with RdValid
//   RdBus    out : right-justified, zero-extended read data (held between reads)
//   RdValid  out : one-cycle pulse marking valid RdBus
//   Ready    out : block accepts requests
// ----------------------------------------------------------------------------
module memory_param
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          WrEn,
    input  logic                          RdEn,
    input  logic [1:0]                    Opcode,
    input  logic [ADDR_W-1:0]             Addr,
    input  logic [$clog2(DATA_W/8)-1:0]   ByteAddr,
    input  logic [$clog2(DATA_W)-1:0]     BitAddr,
    input  logic [DATA_W-1:0]             WrBus,
`ifdef MEMORY_PARAM_PARITY_EN
    input  logic                          ParInj,
    output logic                          RdErr,
`endif
    output logic [DATA_W-1:0]             RdBus,
    output logic                          RdValid,
    output logic                          Ready
);

    localparam int DEPTH = 2**ADDR_W;

    state_e              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   field_mask;
    logic [DATA_W-1:0]   wr_aligned;
    logic [DATA_W-1:0]   rd_field;
    logic                rd_accept;
    logic                wr_accept;

    assign Ready     = (state_reg == ST_IDLE);
    assign rd_accept = Ready & RdEn;
    assign wr_accept = Ready & WrEn;

    // Sub-word writes are read-modify-write, so the addressed word is read
    // combinationally; the same value feeds the read path, which is what makes
    // a same-cycle read return pre-write data.
    assign cur_word = mem[Addr];
    assign wr_word  = (cur_word & ~field_mask) | wr_aligned;

    mem_field #(
        .DATA_W (DATA_W)
    ) u_field (
        .opcode     (Opcode),
        .byte_addr  (ByteAddr),
        .bit_addr   (BitAddr),
        .wr_data    (WrBus),
        .word       (cur_word),
        .field_mask (field_mask),
        .wr_aligned (wr_aligned),
        .rd_field   (rd_field)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_INIT;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_INIT: begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
                if (clr_ptr_reg == '1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_INIT;
                clr_ptr_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage (no reset: the clear sweep initialises it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT) begin
            mem[clr_ptr_reg] <= '0;
        end else if (wr_accept) begin
            mem[Addr] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read return: RdBus only updates on an accepted read, so it holds
    // between pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RdBus   <= '0;
            RdValid <= 1'b0;
        end else begin
            RdValid <= rd_accept;
            if (rd_accept) begin
                RdBus <= rd_field;
            end
        end
    end

`ifdef MEMORY_PARAM_PARITY_EN
    // ------------------------------------------------------------------
    // Per-lane even parity. A lane is rewritten when the field mask touches
    // any of its bits; untouched lanes keep their stored parity.
    // ------------------------------------------------------------------
    localparam int LANES = DATA_W / 8;

    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] cur_par;
    logic [LANES-1:0] word_par;
    logic [LANES-1:0] new_par;

    assign cur_par = par_mem[Addr];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic lane_touch;
        assign lane_touch   = |field_mask[8*gi +: 8];
        assign word_par[gi] = ^cur_word[8*gi +: 8];
        assign new_par[gi]  = lane_touch ? ((^wr_word[8*gi +: 8]) ^ ParInj)
                                         : cur_par[gi];
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT) begin
            par_mem[clr_ptr_reg] <= '0;
        end else if (wr_accept) begin
            par_mem[Addr] <= new_par;
        end
    end

    // Whole-word check regardless of access size.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RdErr <= 1'b0;
        end else if (rd_accept) begin
            RdErr <= |(word_par ^ cur_par);
        end
    end
`endif

endmodule

// File: tb/tb_memory_param.sv
// ----------------------------------------------------------------------------
// tb_memory_param
// Directed, table-driven bench for memory_param at ADDR_W=4, DATA_W=32.
// Build with MEMORY_PARAM_PARITY_EN defined to include the parity scenario.
// ----------------------------------------------------------------------------
module tb_memory_param;
    import mem_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic        clk;
    logic        reset;
    logic        WrEn;
    logic        RdEn;
    logic [1:0]  Opcode;
    logic [3:0]  Addr;
    logic [1:0]  ByteAddr;
    logic [4:0]  BitAddr;
    logic [31:0] WrBus;
    logic        par_inj;
    logic        rd_err;
    logic [31:0] RdBus;
    logic        RdValid;
    logic        Ready;

    int checks   = 0;
    int failures = 0;

    memory_param #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .WrEn     (WrEn),
        .RdEn     (RdEn),
        .Opcode   (Opcode),
        .Addr     (Addr),
        .ByteAddr (ByteAddr),
        .BitAddr  (BitAddr),
        .WrBus    (WrBus),
`ifdef MEMORY_PARAM_PARITY_EN
        .ParInj   (par_inj),
        .RdErr    (rd_err),
`endif
        .RdBus    (RdBus),
        .RdValid  (RdValid),
        .Ready    (Ready)
    );

`ifndef MEMORY_PARAM_PARITY_EN
    assign rd_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [1:0]  ba;
        logic [4:0]  bi;
        logic [31:0] wd;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic re, input logic [1:0] op,
                                input logic [3:0] addr, input logic [1:0] ba,
                                input logic [4:0] bi, input logic [31:0] wd,
                                input logic exp_v, input logic [31:0] exp_d);
        vec_t v;
        v.we = we; v.re = re; v.op = op; v.addr = addr; v.ba = ba;
        v.bi = bi; v.wd = wd; v.exp_v = exp_v; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request per cycle: drive on the falling edge, sample 1 unit after
    // the rising edge that accepts it.
    task automatic drive(input logic we, input logic re, input logic [1:0] op,
                         input logic [3:0] a, input logic [1:0] ba, input logic [4:0] bi,
                         input logic [31:0] wd, input logic inj);
        @(negedge clk);
        WrEn = we; RdEn = re; Opcode = op; Addr = a;
        ByteAddr = ba; BitAddr = bi; WrBus = wd; par_inj = inj;
        @(posedge clk);
        #1;
        WrEn = 1'b0; RdEn = 1'b0; par_inj = 1'b0;
    endtask

    // Counts rising edges until Ready rises; also counts any RdValid seen.
    task automatic wait_ready(output int n, output int spurious);
        n = 0;
        spurious = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (RdValid) spurious++;
            if (Ready) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int spurious;

        reset = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Opcode = 2'd0; Addr = '0;
        ByteAddr = '0; BitAddr = '0; WrBus = '0; par_inj = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdbus",   RdBus,          32'h0);
        check("reset_rdvalid", 32'(RdValid),   32'h0);
        check("reset_ready",   32'(Ready),     32'h0);

        // Release, with requests held high during the sweep: they must be ignored.
        @(negedge clk);
        reset = 1'b1;
        WrEn = 1'b1; RdEn = 1'b1; Opcode = OP_WORD; Addr = 4'd0; WrBus = 32'hFFFFFFFF;
        wait_ready(n, spurious);
        WrEn = 1'b0; RdEn = 1'b0;
        $display("init sweep: %0d cycles", n);
        check("init_cycles",        32'(n),        32'd16);
        check("init_no_rdvalid",    32'(spurious), 32'd0);

        // ---------------- table-driven vectors ----------------
        vq.push_back(mk(0, 1, OP_WORD, 4'd0, 2'd0, 5'd0,  32'h0,        1, 32'h00000000));
        vq.push_back(mk(1, 0, OP_WORD, 4'd3, 2'd0, 5'd0,  32'hDEADBEEF, 0, 32'h00000000));
        vq.push_back(mk(1, 0, OP_BYTE, 4'd3, 2'd2, 5'd0,  32'h00000011, 0, 32'h00000000));
        vq.push_back(mk(0, 1, OP_WORD, 4'd3, 2'd0, 5'd0,  32'h0,        1, 32'hDE11BEEF));
        vq.push_back(mk(1, 0, OP_BIT,  4'd3, 2'd0, 5'd31, 32'h00000000, 0, 32'hDE11BEEF));
        vq.push_back(mk(0, 1, OP_WORD, 4'd3, 2'd0, 5'd0,  32'h0,        1, 32'h5E11BEEF));
        vq.push_back(mk(0, 1, OP_HALF, 4'd3, 2'd2, 5'd0,  32'h0,        1, 32'h00005E11));
        vq.push_back(mk(0, 1, OP_HALF, 4'd3, 2'd3, 5'd0,  32'h0,        1, 32'h00005E11));
        vq.push_back(mk(0, 1, OP_BIT,  4'd3, 2'd0, 5'd0,  32'h0,        1, 32'h00000001));
        vq.push_back(mk(0, 1, OP_BYTE, 4'd3, 2'd1, 5'd0,  32'h0,        1, 32'h000000BE));
        vq.push_back(mk(1, 1, OP_WORD, 4'd5, 2'd0, 5'd0,  32'hA5A5A5A5, 1, 32'h00000000));
        vq.push_back(mk(0, 1, OP_WORD, 4'd5, 2'd0, 5'd0,  32'h0,        1, 32'hA5A5A5A5));
        vq.push_back(mk(1, 0, OP_HALF, 4'd6, 2'd1, 5'd0,  32'hFFFF1234, 0, 32'hA5A5A5A5));
        vq.push_back(mk(0, 1, OP_WORD, 4'd6, 2'd0, 5'd0,  32'h0,        1, 32'h00001234));
        vq.push_back(mk(1, 0, OP_WORD, 4'd1, 2'd0, 5'd0,  32'h12345678, 0, 32'h00001234));
        vq.push_back(mk(1, 0, OP_BYTE, 4'd2, 2'd3, 5'd0,  32'h000000AB, 0, 32'h00001234));
        vq.push_back(mk(0, 1, OP_WORD, 4'd0, 2'd0, 5'd0,  32'h0,        1, 32'h00000000));
        vq.push_back(mk(0, 1, OP_WORD, 4'd1, 2'd0, 5'd0,  32'h0,        1, 32'h12345678));
        vq.push_back(mk(0, 1, OP_WORD, 4'd2, 2'd0, 5'd0,  32'h0,        1, 32'hAB000000));
        vq.push_back(mk(0, 1, OP_WORD, 4'd3, 2'd0, 5'd0,  32'h0,        1, 32'h5E11BEEF));
        vq.push_back(mk(1, 0, OP_BIT,  4'd3, 2'd0, 5'd4,  32'hFFFFFFFF, 0, 32'h5E11BEEF));
        vq.push_back(mk(0, 1, OP_BIT,  4'd3, 2'd0, 5'd4,  32'h0,        1, 32'h00000001));
        vq.push_back(mk(0, 0, OP_WORD, 4'd0, 2'd0, 5'd0,  32'h0,        0, 32'h00000001));
        vq.push_back(mk(0, 1, OP_WORD, 4'd3, 2'd0, 5'd0,  32'h0,        1, 32'h5E11BEFF));

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].re, vq[i].op, vq[i].addr, vq[i].ba, vq[i].bi, vq[i].wd, 1'b0);
            $display("vec %0d: we=%0b re=%0b op=%0d addr=%0d rd_valid=%0b rd_bus=%h",
                     i, vq[i].we, vq[i].re, vq[i].op, vq[i].addr, RdValid, RdBus);
            check($sformatf("vec%0d_rdvalid", i), 32'(RdValid), 32'(vq[i].exp_v));
            check($sformatf("vec%0d_rdbus", i),   RdBus,        vq[i].exp_d);
        end

        // ---------------- reset during a read ----------------
        // Read accepted, then reset asserted while the result is on the bus.
        @(negedge clk);
        RdEn = 1'b1; Opcode = OP_WORD; Addr = 4'd3;
        @(posedge clk);
        #1;
        $display("read before reset: rd_valid=%0b rd_bus=%h", RdValid, RdBus);
        check("pre_reset_rdvalid", 32'(RdValid), 32'd1);
        check("pre_reset_rdbus",   RdBus,        32'h5E11BEFF);
        reset = 1'b0;
        #1;
        check("async_reset_rdvalid", 32'(RdValid), 32'd0);
        check("async_reset_rdbus",   RdBus,        32'h0);
        check("async_reset_ready",   32'(Ready),   32'd0);
        // RdEn stays high through reset and the new sweep: nothing is accepted.
        @(posedge clk);
        #1;
        check("in_reset_rdvalid", 32'(RdValid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n, spurious);
        RdEn = 1'b0;
        $display("re-init sweep: %0d cycles", n);
        check("reinit_cycles",     32'(n),        32'd16);
        check("reinit_no_rdvalid", 32'(spurious), 32'd0);

        drive(0, 1, OP_WORD, 4'd3, 2'd0, 5'd0, 32'h0, 1'b0);
        $display("read addr 3 after re-init: rd_valid=%0b rd_bus=%h", RdValid, RdBus);
        check("reinit_addr3_rdvalid", 32'(RdValid), 32'd1);
        check("reinit_addr3_rdbus",   RdBus,        32'h0);
        drive(0, 1, OP_WORD, 4'd5, 2'd0, 5'd0, 32'h0, 1'b0);
        check("reinit_addr5_rdbus",   RdBus,        32'h0);

`ifdef MEMORY_PARAM_PARITY_EN
        // ---------------- parity ----------------
        drive(1, 0, OP_WORD, 4'd7, 2'd0, 5'd0, 32'h12345678, 1'b1);
        drive(0, 1, OP_WORD, 4'd7, 2'd0, 5'd0, 32'h0, 1'b0);
        $display("parity inj read: rd_valid=%0b rd_err=%0b rd_bus=%h", RdValid, rd_err, RdBus);
        check("par_inj_rdvalid", 32'(RdValid), 32'd1);
        check("par_inj_rderr",   32'(rd_err),  32'd1);
        check("par_inj_rdbus",   RdBus,        32'h12345678);
        drive(1, 0, OP_WORD, 4'd7, 2'd0, 5'd0, 32'h12345678, 1'b0);
        drive(0, 1, OP_WORD, 4'd7, 2'd0, 5'd0, 32'h0, 1'b0);
        $display("parity clean read: rd_valid=%0b rd_err=%0b", RdValid, rd_err);
        check("par_clean_rdvalid", 32'(RdValid), 32'd1);
        check("par_clean_rderr",   32'(rd_err),  32'd0);
        // Byte write with injection flags the whole-word check on a bit read.
        drive(1, 0, OP_BYTE, 4'd7, 2'd1, 5'd0, 32'h000000C3, 1'b1);
        drive(0, 1, OP_BIT,  4'd7, 2'd0, 5'd0, 32'h0, 1'b0);
        check("par_byte_inj_rderr", 32'(rd_err), 32'd1);
        check("par_byte_inj_rdbus", RdBus,       32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
